// File: rtl/mem_write_arbiter_pkg.sv
// Shared types and helpers for the matrix-memory write-port arbiter.
package mem_arb_pkg;

   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_BURST = 1'b1
   } arb_state_t;

   localparam logic ARB_FIXED = 1'b0;
   localparam logic ARB_RR    = 1'b1;

   function automatic int ch_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/mem_write_arbiter_picker.sv
// Combinational pick of the first requesting channel at or after ptr, wrapping.
module rr_priority_picker #(
   parameter int N  = 3,
   parameter int PW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic          found,
   output logic [PW-1:0] idx
);

   // Scan offsets from farthest to nearest so the nearest requester is written last.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[(int'(ptr) + i) % N]) begin
            found = 1'b1;
            idx   = PW'((int'(ptr) + i) % N);
         end
      end
   end

endmodule

// File: rtl/mem_write_arbiter.sv
// Write-port arbiter: N writers share one registered memory write port,
// with fixed/round-robin selection, burst ownership and an idle-owner watchdog.
module mem_write_arbiter
   import mem_arb_pkg::*;
#(
   parameter int NUM_CH  = 3,
   parameter int ID_W    = 7,
   parameter int IDX_W   = 4,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255,
   parameter int CH_W    = ch_width(NUM_CH)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     arb_mode,
   input  logic [NUM_CH-1:0]        ch_valid,
   input  logic [NUM_CH-1:0]        ch_last,
   input  logic [NUM_CH*ID_W-1:0]   ch_id,
   input  logic [NUM_CH*IDX_W-1:0]  ch_row,
   input  logic [NUM_CH*IDX_W-1:0]  ch_col,
   input  logic [NUM_CH*DATA_W-1:0] ch_data,
   output logic [NUM_CH-1:0]        ch_ready,
   output logic                     mem_we,
   output logic [ID_W-1:0]          mem_id_w,
   output logic [IDX_W-1:0]         mem_row_w,
   output logic [IDX_W-1:0]         mem_col_w,
   output logic [DATA_W-1:0]        mem_data_w,
   output logic                     busy,
   output logic [CH_W-1:0]          grant_ch,
   output logic                     burst_abort,
   output arb_state_t               dbg_state
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   // Handshake: a beat moves on a rising edge exactly when ch_valid[k] & ch_ready[k];
   // ch_ready never depends on the same channel's valid during a burst, so the owner
   // may present valid at any time and is served in the cycle it does.
   arb_state_t       state, state_nx;
   logic [CH_W-1:0]  owner, rr_ptr, pick_ptr, pick, sel, sel_inc;
   logic [CNT_W-1:0] idle_cnt;
   logic             pick_found, xfer, sel_last, idle_hit, abort_nx;

   assign pick_ptr = (arb_mode == ARB_RR) ? rr_ptr : '0;

   rr_priority_picker #(
      .N  (NUM_CH),
      .PW (CH_W)
   ) u_picker (
      .req   (ch_valid),
      .ptr   (pick_ptr),
      .found (pick_found),
      .idx   (pick)
   );

   assign sel      = (state == ARB_IDLE) ? pick : owner;
   assign sel_inc  = (sel == CH_W'(NUM_CH - 1)) ? '0 : sel + 1'b1;
   assign xfer     = |(ch_valid & ch_ready);
   assign sel_last = ch_last[sel];
   assign idle_hit = (state == ARB_BURST) && !ch_valid[owner] &&
                     (idle_cnt == CNT_W'(TIMEOUT - 1));
   assign dbg_state = state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ARB_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      abort_nx = 1'b0;
      case (state)
         ARB_IDLE:  if (xfer && !sel_last) state_nx = ARB_BURST;
         ARB_BURST: begin
            if (xfer && sel_last) begin
               state_nx = ARB_IDLE;
            end else if (idle_hit) begin
               state_nx = ARB_IDLE;
               abort_nx = 1'b1;
            end
         end
         default:   state_nx = ARB_IDLE;
      endcase
   end

   always_comb begin
      ch_ready = '0;
      if (!rst) begin
         if (state == ARB_BURST) ch_ready[owner] = 1'b1;
         else if (pick_found)    ch_ready[pick]  = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner       <= '0;
         rr_ptr      <= '0;
         idle_cnt    <= '0;
         mem_we      <= 1'b0;
         mem_id_w    <= '0;
         mem_row_w   <= '0;
         mem_col_w   <= '0;
         mem_data_w  <= '0;
         busy        <= 1'b0;
         grant_ch    <= '0;
         burst_abort <= 1'b0;
      end else begin
         mem_we      <= xfer;
         busy        <= (state_nx == ARB_BURST);
         burst_abort <= abort_nx;
         if (xfer) begin
            owner      <= sel;
            grant_ch   <= sel;
            mem_id_w   <= ch_id[int'(sel)*ID_W +: ID_W];
            mem_row_w  <= ch_row[int'(sel)*IDX_W +: IDX_W];
            mem_col_w  <= ch_col[int'(sel)*IDX_W +: IDX_W];
            mem_data_w <= ch_data[int'(sel)*DATA_W +: DATA_W];
         end
         if ((xfer && sel_last) || abort_nx) rr_ptr <= sel_inc;
         if ((state == ARB_BURST) && !xfer && !abort_nx) idle_cnt <= idle_cnt + 1'b1;
         else                                            idle_cnt <= '0;
      end
   end

endmodule
